// File: rtl/uart_rx_pkg.sv
// uart_pkg: constants and receiver state encoding shared by the UART rx and tx blocks.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned DEFAULT_DIVIDER = 1736;  // 200 MHz / 115200 baud
    localparam int unsigned IDX_W           = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Parity bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out.
// Optional macro UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 in;
    logic [DATA_BITS-1:0] out;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (
        output in,
        input  out,
        input  valid,
        input  frame_err,
        input  busy,
        input  parity_err
    );

    modport slave (
        input  in,
        output out,
        output valid,
        output frame_err,
        output busy,
        output parity_err
    );
`else
    modport master (
        output in,
        input  out,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  in,
        output out,
        output valid,
        output frame_err,
        output busy
    );
`endif

endinterface

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so the output is defined during and after reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the raw input through two flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= {2{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first, idle-high line), centre-sampled bits,
// one-cycle valid / frame_err strobes. Reset (port 'reset') is async active-low.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIVIDER = DEFAULT_DIVIDER,
    parameter int unsigned CNT_W   = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave rx
);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(DIVIDER / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(DIVIDER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    logic                 cnt_zero;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rx.in),
        .q_o   (rxs)
    );

    assign cnt_zero = (cnt_q == '0);

    // Next-state, counter, shift register and strobe logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_RELOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_RELOAD;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_zero) begin
                    par_d   = rxs;
                    cnt_d   = FULL_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity(shift_q) != par_q) begin
                            perr_d = 1'b1;
                        end else begin
                            out_d   = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        out_d   = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx.out       = out_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with DIVIDER=8.
// Honours UART_RX_PARITY_EN (adds the parity bit and parity_err checks).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // in driven low after edge E0 -> rxs low after E0+2 -> FSM sees it at E0+3,
    // strobe registered at the stop-sample edge.
    localparam int LAT = 3 + DIV / 2 + (NBITS - 1) * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_rx_if ifc ();

    uart_rx #(
        .DIVIDER (DIV),
        .CNT_W   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (ifc.slave)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int fcount = 0;
    int pcount = 0;
    int unsigned last_strobe_cyc = 0;
    int unsigned start_cyc = 0;
    logic [7:0] vq[$];
    int unsigned cq[$];

    // Strobe monitor.
    always @(negedge clk) begin
        if (ifc.valid || ifc.frame_err) begin
            last_strobe_cyc = cyc;
            checks++;
            if (ifc.valid && ifc.frame_err) begin
                errors++;
                $display("FAIL strobe_excl valid=1 frame_err=1 required=not both");
            end
        end
        if (ifc.valid) begin
            vcount++;
            vq.push_back(ifc.out);
            cq.push_back(cyc);
        end
        if (ifc.frame_err) fcount++;
`ifdef UART_RX_PARITY_EN
        if (ifc.parity_err) begin
            pcount++;
            checks++;
            if (ifc.valid) begin
                errors++;
                $display("FAIL parity_excl valid=1 parity_err=1 required=not both");
            end
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at edge+1ns; leaves at edge+1ns after n edges.
    task automatic drive(input logic b, input int n);
        ifc.in = b;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        start_cyc = cyc;
        drive(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive(d[i], DIV);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ pflip, DIV);
`else
        if (pflip) $display("note: parity flip ignored in this build");
`endif
        drive(stop, DIV);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold_low;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, p0, exp_ferr, exp_perr;
        logic seen_busy;
        logic [7:0] d;
        logic stop, pflip;
        logic [7:0] exp_q[$];

        tbl[0] = '{8'hB2, 1'b1, 0,  1, 0, 8'hB2};
        tbl[1] = '{8'h55, 1'b0, 30, 0, 1, 8'hB2};
        tbl[2] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C};
        tbl[3] = '{8'h81, 1'b1, 0,  1, 0, 8'h81};

        // Reset values.
        ifc.in = 1'b1;
        reset  = 1'b0;
        #50;
        chk("rst_out", ifc.out, 8'h00);
        chk("rst_valid", ifc.valid, 0);
        chk("rst_ferr", ifc.frame_err, 0);
        chk("rst_busy", ifc.busy, 0);
        #50 reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 2 * DIV);

        // Table-driven frames.
        for (int k = 0; k < 4; k++) begin
            v0 = vcount;
            f0 = fcount;
            send_frame(tbl[k].data, tbl[k].stop, 1'b0);
            if (tbl[k].hold_low > 0) begin
                drive(1'b0, tbl[k].hold_low);
                chk($sformatf("busy_break[%0d]", k), ifc.busy, 1);
            end
            drive(1'b1, 2 * DIV);
            chk($sformatf("valid_cnt[%0d]", k), vcount - v0, tbl[k].exp_valid);
            chk($sformatf("ferr_cnt[%0d]", k), fcount - f0, tbl[k].exp_ferr);
            chk($sformatf("out[%0d]", k), ifc.out, tbl[k].exp_out);
            chk($sformatf("latency[%0d]", k), last_strobe_cyc - start_cyc, LAT);
            chk($sformatf("busy_idle[%0d]", k), ifc.busy, 0);
        end

        // Back-to-back frames, no idle gap.
        vq.delete();
        cq.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 2 * DIV);
        chk("b2b_count", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("b2b_first", vq[0], 8'h00);
            chk("b2b_second", vq[1], 8'hFF);
            chk("b2b_spacing", cq[1] - cq[0], NBITS * DIV);
        end

        // Short low glitch on an idle line.
        v0 = vcount;
        f0 = fcount;
        seen_busy = 1'b0;
        drive(1'b0, 3);
        ifc.in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ifc.busy) seen_busy = 1'b1;
        end
        @(posedge clk); #1;
        drive(1'b1, 2 * DIV);
        chk("glitch_busy_seen", seen_busy, 1);
        chk("glitch_busy_idle", ifc.busy, 0);
        chk("glitch_valid", vcount - v0, 0);
        chk("glitch_ferr", fcount - f0, 0);

        // Reset asserted during bit 4.
        d = 8'h5A;
        drive(1'b0, DIV);
        for (int i = 0; i < 4; i++) drive(d[i], DIV);
        drive(d[4], DIV / 2);
        #1 reset = 1'b0;
        #1;
        chk("midrst_out", ifc.out, 8'h00);
        chk("midrst_valid", ifc.valid, 0);
        chk("midrst_ferr", ifc.frame_err, 0);
        chk("midrst_busy", ifc.busy, 0);
        ifc.in = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        v0 = vcount;
        f0 = fcount;
        repeat (12 * DIV) @(posedge clk);
        #1;
        chk("postrst_valid", vcount - v0, 0);
        chk("postrst_ferr", fcount - f0, 0);
        chk("postrst_out", ifc.out, 8'h00);
        v0 = vcount;
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 2 * DIV);
        chk("postrst_a5_valid", vcount - v0, 1);
        chk("postrst_a5_out", ifc.out, 8'hA5);

`ifdef UART_RX_PARITY_EN
        // Parity: correct then flipped parity bit.
        v0 = vcount;
        p0 = pcount;
        send_frame(8'hB2, 1'b1, 1'b0);
        drive(1'b1, 2 * DIV);
        chk("par_ok_valid", vcount - v0, 1);
        chk("par_ok_out", ifc.out, 8'hB2);
        chk("par_ok_perr", pcount - p0, 0);
        v0 = vcount;
        p0 = pcount;
        send_frame(8'hB2, 1'b1, 1'b1);
        drive(1'b1, 2 * DIV);
        chk("par_bad_valid", vcount - v0, 0);
        chk("par_bad_perr", pcount - p0, 1);
`endif

        // Random frames against a frame-level reference model.
        vq.delete();
        exp_q.delete();
        exp_ferr = 0;
        exp_perr = 0;
        f0 = fcount;
        p0 = pcount;
        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 4) != 0);
            pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (stop) pflip = ($urandom_range(0, 3) == 0);
`endif
            send_frame(d, stop, pflip);
            if (!stop) begin
                exp_ferr++;
                drive(1'b0, $urandom_range(0, DIV));
                drive(1'b1, DIV + $urandom_range(0, DIV));
            end else begin
                if (pflip) exp_perr++;
                else exp_q.push_back(d);
                drive(1'b1, $urandom_range(0, DIV));
            end
        end
        drive(1'b1, 2 * DIV);
        chk("rand_count", vq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < vq.size(); i++) begin
            chk($sformatf("rand_byte[%0d]", i), vq[i], exp_q[i]);
        end
        chk("rand_ferr", fcount - f0, exp_ferr);
        chk("rand_perr", pcount - p0, exp_perr);
        if (exp_q.size() > 0) chk("rand_out_hold", ifc.out, exp_q[exp_q.size() - 1]);
        chk("rand_busy_idle", ifc.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
